// File: rtl/aespim_pkg.sv
// Types shared by the AES PIM accelerator datapath and its command sequencer.
package aespim_pkg;

    localparam int unsigned NUM_WORDS = 4;

    typedef enum logic [3:0] {
        ACC_LD  = 4'h0,
        ACC_ST  = 4'h1,
        ACC_KEX = 4'h2,
        ACC_NOP = 4'hF
    } acc_op_e;

    typedef enum logic [1:0] {
        CMD_LOAD    = 2'd0,
        CMD_STORE   = 2'd1,
        CMD_KEX     = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_STORE = 3'd2,
        SEQ_KEX   = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_e;

    // Maps an accepted command to the sequencer state that services it.
    function automatic seq_state_e cmd_target(input cmd_e cmd);
        case (cmd)
            CMD_LOAD:  return SEQ_LOAD;
            CMD_STORE: return SEQ_STORE;
            CMD_KEX:   return SEQ_KEX;
            default:   return SEQ_DONE;
        endcase
    endfunction

endpackage

// File: rtl/aespim_sequencer.sv
// Command sequencer driving the AES PIM accelerator: LOAD/STORE word streaming
// and timed key expansion; the accelerator sees NOP whenever nothing is moving.
module aespim_sequencer
    import aespim_pkg::*;
#(
    parameter int unsigned NumWords  = NUM_WORDS,
    parameter int unsigned KexCycles = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [31:0] wdata_i,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        acc_start_o,
    output logic [3:0]  acc_op_o,
    output logic [31:0] acc_wdata_o,
    input  logic [31:0] acc_rdata_i
);

    localparam int unsigned    CntW    = $clog2(NumWords + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(NumWords - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(NumWords);
    localparam logic [7:0]      KexLoad = 8'(KexCycles);

    seq_state_e      state_r;
    logic [CntW-1:0] word_cnt_r;
    logic [7:0]      kex_cnt_r;
    logic            first_r;
    logic            err_r;
    logic            rvalid_r;
    logic [31:0]     rdata_r;

    cmd_e            cmd_s;
    logic            ld_beat_s;
    logic            st_issue_s;
    logic            consume_s;
    acc_op_e         acc_op_s;
    logic [31:0]     acc_wdata_s;

    assign cmd_s = cmd_e'(req_op_i);

    // Per-cycle stream events: load beat, store issue into the buffer, buffer consume.
    always_comb begin
        ld_beat_s  = 1'b0;
        st_issue_s = 1'b0;
        consume_s  = 1'b0;
        if (state_r == SEQ_LOAD) begin
            ld_beat_s = wdata_valid_i;
        end else if (state_r == SEQ_STORE) begin
            st_issue_s = (word_cnt_r < CntFull) && (!rvalid_r || rdata_ready_i);
            consume_s  = rvalid_r && rdata_ready_i;
        end else begin
            ld_beat_s  = 1'b0;
            st_issue_s = 1'b0;
            consume_s  = 1'b0;
        end
    end

    // Accelerator op code and data; anything that is not a real transfer is NOP with zero data.
    always_comb begin
        acc_op_s    = ACC_NOP;
        acc_wdata_s = 32'h0000_0000;
        case (state_r)
            SEQ_LOAD: begin
                if (ld_beat_s) begin
                    acc_op_s    = ACC_LD;
                    acc_wdata_s = wdata_i;
                end else begin
                    acc_op_s    = ACC_NOP;
                    acc_wdata_s = 32'h0000_0000;
                end
            end
            SEQ_STORE: begin
                if (st_issue_s) begin
                    acc_op_s = ACC_ST;
                end else begin
                    acc_op_s = ACC_NOP;
                end
            end
            SEQ_KEX: begin
                if (first_r) begin
                    acc_op_s = ACC_KEX;
                end else begin
                    acc_op_s = ACC_NOP;
                end
            end
            default: begin
                acc_op_s    = ACC_NOP;
                acc_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer FSM, word/KEX counters and the one-entry read buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= SEQ_IDLE;
            word_cnt_r <= '0;
            kex_cnt_r  <= 8'd0;
            first_r    <= 1'b0;
            err_r      <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            first_r <= 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    if (req_valid_i) begin
                        word_cnt_r <= '0;
                        kex_cnt_r  <= KexLoad;
                        state_r    <= cmd_target(cmd_s);
                        first_r    <= (cmd_s != CMD_ILLEGAL);
                        err_r      <= (cmd_s == CMD_ILLEGAL);
                    end
                end
                SEQ_LOAD: begin
                    if (ld_beat_s) begin
                        word_cnt_r <= word_cnt_r + CntOne;
                        if (word_cnt_r == CntLast) begin
                            state_r <= SEQ_DONE;
                        end
                    end
                end
                SEQ_STORE: begin
                    // An issue and a consume in the same cycle keep the buffer full.
                    if (st_issue_s) begin
                        rdata_r    <= acc_rdata_i;
                        rvalid_r   <= 1'b1;
                        word_cnt_r <= word_cnt_r + CntOne;
                    end else if (consume_s) begin
                        rvalid_r <= 1'b0;
                        if (word_cnt_r == CntFull) begin
                            state_r <= SEQ_DONE;
                        end
                    end
                end
                SEQ_KEX: begin
                    if (kex_cnt_r == 8'd0) begin
                        state_r <= SEQ_DONE;
                    end else begin
                        kex_cnt_r <= kex_cnt_r - 8'd1;
                    end
                end
                SEQ_DONE: begin
                    state_r <= SEQ_IDLE;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_r == SEQ_IDLE);
    assign wdata_ready_o = (state_r == SEQ_LOAD);
    assign rdata_valid_o = rvalid_r;
    assign rdata_o       = rdata_r;
    assign done_o        = (state_r == SEQ_DONE);
    assign err_o         = (state_r == SEQ_DONE) && err_r;
    assign acc_start_o   = first_r;
    assign acc_op_o      = acc_op_s;
    assign acc_wdata_o   = acc_wdata_s;

endmodule

// File: tb/tb_aespim_sequencer.sv
// Self-checking bench for aespim_sequencer: transaction-level reference model,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_aespim_sequencer;

    localparam int NW   = 4;
    localparam int KEXC = 10;
    localparam int M_IDLE = 0, M_LOAD = 1, M_STORE = 2, M_KEX = 3, M_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        rdata_ready = 1'b0;
    logic        req_ready, wdata_ready, rdata_valid, done, err, acc_start;
    logic [31:0] rdata, acc_wdata, acc_rdata;
    logic [3:0]  acc_op;

    always #5 clk = ~clk;

    aespim_sequencer #(.NumWords(NW), .KexCycles(KEXC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .done_o(done), .err_o(err), .acc_start_o(acc_start), .acc_op_o(acc_op),
        .acc_wdata_o(acc_wdata), .acc_rdata_i(acc_rdata)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Accelerator stub: 4-slot shift register fed by the sequencer (not reset by it).
    logic [31:0] acc_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int n_ld = 0;
    int n_st = 0;
    assign acc_rdata = acc_mem[0];
    always @(posedge clk) begin
        if (acc_op == 4'h0) begin
            acc_mem[0] <= acc_mem[1]; acc_mem[1] <= acc_mem[2];
            acc_mem[2] <= acc_mem[3]; acc_mem[3] <= acc_wdata;
            n_ld <= n_ld + 1;
        end else if (acc_op == 4'h1) begin
            acc_mem[0] <= acc_mem[1]; acc_mem[1] <= acc_mem[2];
            acc_mem[2] <= acc_mem[3]; acc_mem[3] <= acc_mem[0];
            n_st <= n_st + 1;
        end
    end

    // Reference model: mode, transfer count, buffered word, and accelerator contents as a queue.
    int          m_mode = M_IDLE;
    int          m_cnt = 0;
    int          m_kex = 0;
    bit          m_first = 1'b0, m_err = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_acc [$] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  m_op;
    logic [31:0] m_w;
    bit          m_consumed;

    function automatic logic [3:0] model_op();
        if (m_mode == M_LOAD && wdata_valid) return 4'h0;
        if (m_mode == M_STORE && m_cnt < NW && (!m_rvalid || rdata_ready)) return 4'h1;
        if (m_mode == M_KEX && m_first) return 4'h2;
        return 4'hF;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_mode = M_IDLE; m_cnt = 0; m_kex = 0;
            m_first = 1'b0; m_err = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        end else begin
            m_op = model_op();
            m_consumed = (m_mode == M_STORE) && m_rvalid && rdata_ready;
            if (m_op == 4'h0) begin
                m_acc.push_back(wdata);
                m_w = m_acc.pop_front();
            end else if (m_op == 4'h1) begin
                m_w = m_acc.pop_front();
                m_acc.push_back(m_w);
                m_rdata = m_w;
            end
            m_first = 1'b0;
            if (m_mode == M_IDLE) begin
                if (req_valid) begin
                    m_cnt = 0; m_kex = 0;
                    m_err = (req_op == 2'd3);
                    m_first = (req_op != 2'd3);
                    m_mode = (req_op == 2'd0) ? M_LOAD : (req_op == 2'd1) ? M_STORE :
                             (req_op == 2'd2) ? M_KEX : M_DONE;
                end
            end else if (m_mode == M_LOAD) begin
                if (m_op == 4'h0) m_cnt++;
                if (m_cnt == NW) m_mode = M_DONE;
            end else if (m_mode == M_STORE) begin
                if (m_op == 4'h1) begin
                    m_rvalid = 1'b1;
                    m_cnt++;
                end else if (m_consumed) begin
                    m_rvalid = 1'b0;
                    if (m_cnt == NW) m_mode = M_DONE;
                end
            end else if (m_mode == M_KEX) begin
                m_kex++;
                if (m_kex == KEXC + 1) m_mode = M_DONE;
            end else begin
                m_mode = M_IDLE;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [3:0] e_op;
    always @(negedge clk) begin
        if (cyc > 0) begin
            e_op = model_op();
            chk("req_ready", req_ready, m_mode == M_IDLE);
            chk("wdata_ready", wdata_ready, m_mode == M_LOAD);
            chk("rdata_valid", rdata_valid, m_rvalid);
            if (m_rvalid) chk("rdata", rdata, m_rdata);
            chk("done", done, m_mode == M_DONE);
            chk("err", err, (m_mode == M_DONE) && m_err);
            chk("acc_start", acc_start, m_first);
            chk("acc_op", acc_op, e_op);
            chk("acc_wdata", acc_wdata, (e_op == 4'h0) ? wdata : 32'h0);
        end
    end

    // Completion and read-stream monitor.
    int n_done = 0, n_err = 0, done_cyc = 0;
    logic [31:0] got [$];
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            done_cyc = cyc;
            if (err) n_err++;
        end
        if (rdata_valid && rdata_ready) got.push_back(rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] op, output int acc_cyc);
        tick();
        req_valid = 1'b1;
        req_op = op;
        tick();
        req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        for (int i = 0; i < budget && n_done < target; i++) tick();
        chk(name, n_done, target);
    endtask

    task automatic load_words(input logic [31:0] w [4], input int gap, input string name);
        int a, d0, l0, beat;
        d0 = n_done; l0 = n_ld; beat = 0;
        start_cmd(2'd0, a);
        for (int k = 0; k < 4; k++) begin
            wdata = w[k]; wdata_valid = 1'b1;
            tick();
            beat = cyc;
            wdata_valid = 1'b0; wdata = 32'hA5A5_5A5A;
            if (k < 3) for (int g = 0; g < gap; g++) tick();
        end
        wait_dones(d0 + 1, 20, {name, "_done_timeout"});
        chk({name, "_done_after_last_beat"}, done_cyc, beat);
        if (gap == 0) chk({name, "_latency"}, done_cyc - a, 4);
        chk({name, "_ld_count"}, n_ld - l0, 4);
        chk({name, "_slot0"}, acc_mem[0], w[0]);
        wdata = 32'h0;
    endtask

    task automatic store_words(input logic [31:0] w [4], input logic [3:0] pat, input string name);
        int a, d0, s0;
        d0 = n_done; s0 = n_st;
        got.delete();
        start_cmd(2'd1, a);
        for (int i = 0; i < 60 && n_done == d0; i++) begin
            rdata_ready = pat[i % 4];
            tick();
        end
        rdata_ready = 1'b0;
        chk({name, "_done_timeout"}, n_done, d0 + 1);
        if (pat == 4'b1111) chk({name, "_latency"}, done_cyc - a, 5);
        chk({name, "_st_count"}, n_st - s0, 4);
        chk({name, "_word_count"}, got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk({name, "_word"}, got[k], w[k]);
    endtask

    logic [31:0] words_a [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [31:0] words_b [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    logic [31:0] words_c [4] = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};

    initial begin
        int a, d0, e0;
        // Reset values.
        tick(); tick();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_acc_op", acc_op, 4'hF);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_acc_wdata", acc_wdata, 32'h0);
        rst_ni = 1'b1;
        // Write data outside LOAD is ignored.
        wdata_valid = 1'b1; wdata = 32'hBAD0BAD0;
        tick(); tick();
        wdata_valid = 1'b0; wdata = 32'h0;

        load_words(words_a, 0, "load_full");
        store_words(words_a, 4'b1111, "store_full");
        load_words(words_b, 2, "load_gap");
        store_words(words_b, 4'b1001, "store_bp");

        // Key expansion.
        d0 = n_done;
        start_cmd(2'd2, a);
        wait_dones(d0 + 1, 30, "kex_done_timeout");
        chk("kex_latency", done_cyc - a, 11);

        // Illegal op held valid: DONE-cycle request ignored, re-accepted after.
        d0 = n_done; e0 = n_err;
        tick();
        req_valid = 1'b1; req_op = 2'd3;
        tick(); a = cyc;
        tick(); tick();
        req_valid = 1'b0; req_op = 2'd0;
        wait_dones(d0 + 2, 10, "illegal_done_count");
        chk("illegal_err_count", n_err - e0, 2);
        chk("illegal_latency", done_cyc - a, 2);

        // Reset after two STORE words have been consumed.
        got.delete();
        start_cmd(2'd1, a);
        rdata_ready = 1'b1;
        tick(); tick(); tick();
        rst_ni = 1'b0;
        #1;
        chk("midrst_rdata_valid", rdata_valid, 1'b0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_acc_op", acc_op, 4'hF);
        chk("midrst_acc_start", acc_start, 1'b0);
        chk("midrst_words", got.size(), 2);
        if (got.size() == 2) begin
            chk("midrst_word0", got[0], words_b[0]);
            chk("midrst_word1", got[1], words_b[1]);
        end
        tick();
        rst_ni = 1'b1;
        rdata_ready = 1'b0;
        load_words(words_c, 0, "load_after_rst");
        store_words(words_c, 4'b1111, "store_after_rst");

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
